// File: rtl/condicionador_botoes.sv
// Push-button conditioner: two-flop synchronizer, debouncer and a press/release
// FSM that emits one event per accepted press of the four game buttons.
module condicionador_botoes #(
    parameter int DEBOUNCE = 5
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [3:0] botoes_i,
    output logic [3:0] jogada_o,
    output logic       tem_jogada_o,
    output logic       jogada_invalida_o,
    output logic [1:0] db_estado_o
);

    typedef enum logic [1:0] {
        DESAB          = 2'b00,
        SOLTO          = 2'b01,
        PRESS          = 2'b10,
        ESPERA_SOLTURA = 2'b11
    } estado_t;

    localparam logic [7:0] DB_MAX = 8'(DEBOUNCE);
    localparam logic [7:0] DB_PRE = 8'(DEBOUNCE - 2);

    logic [3:0] s1_q, s2_q, prev_q, est_q, est_d;
    logic [7:0] cnt_q, cnt_d;
    estado_t    state_q, state_d;
    logic [3:0] jogada_q, jogada_d;
    logic       tem_q, tem_d;
    logic       inv_q, inv_d;
    logic       settled_s;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Debounce counter and stable-vector update
    always_comb begin
        cnt_d = cnt_q;
        est_d = est_q;
        if (s2_q != prev_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q < DB_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if ((s2_q == prev_q) && (cnt_q == DB_PRE)) begin
            est_d = s2_q;
        end else begin
            est_d = est_q;
        end
    end

    // Leaving DESAB waits for the debouncer to settle, so a button held through
    // reset is seen as held (and must be released) rather than as a new press.
    assign settled_s = (cnt_q == DB_MAX) && (s2_q == prev_q) && (s1_q == s2_q);

    // FSM next state and event generation
    always_comb begin
        state_d  = state_q;
        jogada_d = jogada_q;
        tem_d    = 1'b0;
        inv_d    = 1'b0;
        case (state_q)
            DESAB: begin
                if (enable_i && settled_s) begin
                    state_d = (est_q == 4'b0000) ? SOLTO : ESPERA_SOLTURA;
                end else begin
                    state_d = DESAB;
                end
            end
            SOLTO: begin
                if (!enable_i) begin
                    state_d = DESAB;
                end else if (one_hot(est_q)) begin
                    tem_d    = 1'b1;
                    jogada_d = est_q;
                    state_d  = PRESS;
                end else if (est_q != 4'b0000) begin
                    inv_d   = 1'b1;
                    state_d = ESPERA_SOLTURA;
                end else begin
                    state_d = SOLTO;
                end
            end
            PRESS: begin
                if (!enable_i) begin
                    state_d = ESPERA_SOLTURA;
                end else if (est_q == 4'b0000) begin
                    state_d = SOLTO;
                end else begin
                    state_d = PRESS;
                end
            end
            ESPERA_SOLTURA: begin
                if (est_q == 4'b0000) begin
                    state_d = enable_i ? SOLTO : DESAB;
                end else begin
                    state_d = ESPERA_SOLTURA;
                end
            end
            default: begin
                state_d = DESAB;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_q     <= 4'b0000;
            s2_q     <= 4'b0000;
            prev_q   <= 4'b0000;
            est_q    <= 4'b0000;
            cnt_q    <= 8'd0;
            state_q  <= DESAB;
            jogada_q <= 4'b0000;
            tem_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            s1_q     <= botoes_i;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            est_q    <= est_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            jogada_q <= jogada_d;
            tem_q    <= tem_d;
            inv_q    <= inv_d;
        end
    end

    assign jogada_o          = jogada_q;
    assign tem_jogada_o      = tem_q;
    assign jogada_invalida_o = inv_q;
    assign db_estado_o       = state_q;

endmodule
